// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding and frame/word geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int FRAME_BITS     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = FRAME_BITS * BYTES_PER_WORD;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: line synchronizer, mid-bit sampling FSM, byte and frame-error pulses.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serial,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_done,
  output logic                  rx_err,
  output logic [FRAME_BITS-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [TW-1:0] HALF_CNT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_CNT = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  logic [1:0]            sync_reg;
  logic                  line;
  rx_state_t             state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [FRAME_BITS-1:0] byte_reg, byte_next;
  logic                  byte_valid_reg, byte_valid_next;
  logic                  frame_err_reg, frame_err_next;

  assign line = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg       <= 2'b11;
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], serial};
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      byte_reg       <= byte_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    byte_next       = byte_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    rx_done         = 1'b0;
    rx_err          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!line) begin
          state_next = ST_START;
          timer_next = '0;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in to reject glitches.
        if (timer_reg == HALF_CNT) begin
          timer_next = '0;
          if (!line) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (timer_reg == FULL_CNT) begin
          timer_next   = '0;
          shift_next   = {line, shift_reg[FRAME_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) state_next = ST_STOP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (timer_reg == FULL_CNT) begin
          timer_next = '0;
          if (line) begin
            byte_next       = shift_reg;
            byte_valid_next = 1'b1;
            rx_done         = 1'b1;
            state_next      = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            rx_err         = 1'b1;
            state_next     = ST_BREAK_WAIT;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_BREAK_WAIT: begin
        if (line) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_data    = shift_reg;
  assign byte_out   = byte_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg == ST_DATA) || (state_reg == ST_STOP) ||
                      (state_reg == ST_BREAK_WAIT);

endmodule

// File: rtl/serial_to_word_rx.sv
// UART receiver top: byte reception plus optional assembly of 4 bytes into a big-endian word.
module serial_to_word_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  sys_clk,
  input  logic                  sw_0,
  input  logic                  i_serial,
  input  logic                  i_mode_select,
  output logic [FRAME_BITS-1:0] o_byte,
  output logic                  o_byte_valid,
  output logic [WORD_BITS-1:0]  o_word,
  output logic                  o_word_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_WORD - 1);

  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_done;
  logic                  rx_err;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [WORD_BITS-1:0]  acc_reg, acc_next;
  logic [WORD_BITS-1:0]  word_reg, word_next;
  logic                  word_valid_reg, word_valid_next;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (sys_clk),
    .rst_n     (sw_0),
    .serial    (i_serial),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .byte_out  (o_byte),
    .byte_valid(o_byte_valid),
    .frame_err (o_frame_err),
    .busy      (o_busy)
  );

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      cnt_reg        <= '0;
      acc_reg        <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      acc_reg        <= acc_next;
      word_reg       <= word_next;
      word_valid_reg <= word_valid_next;
    end
  end

  // Acts on the stop-sample strobe so the word pulse registers alongside o_byte_valid.
  always_comb begin
    cnt_next        = cnt_reg;
    acc_next        = acc_reg;
    word_next       = word_reg;
    word_valid_next = 1'b0;
    if (rx_err) begin
      cnt_next = '0;
      acc_next = '0;
    end else if (rx_done) begin
      if (i_mode_select) begin
        acc_next = {acc_reg[WORD_BITS-FRAME_BITS-1:0], rx_data};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_BYTE) begin
          word_next       = acc_next;
          word_valid_next = 1'b1;
        end
      end else begin
        cnt_next = '0;
        acc_next = '0;
      end
    end
  end

  assign o_word       = word_reg;
  assign o_word_valid = word_valid_reg;

endmodule

// File: tb/tb_serial_to_word_rx.sv
// Directed bench for serial_to_word_rx: UART frames driven bit by bit, outputs checked against a scoreboard.
module tb_serial_to_word_rx;

  localparam int C = 20;

  logic        sys_clk = 1'b0;
  logic        sw_0 = 1'b0;
  logic        i_serial = 1'b1;
  logic        i_mode_select = 1'b0;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        o_frame_err;
  logic        o_busy;

  int total = 0;
  int bad = 0;
  logic [7:0]  byte_q[$];
  logic [31:0] word_q[$];
  int          err_exp = 0;
  logic        prev_bv = 1'b0;
  logic        prev_wv = 1'b0;
  logic        prev_fe = 1'b0;

  always #5 sys_clk = ~sys_clk;

  serial_to_word_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .sys_clk      (sys_clk),
    .sw_0         (sw_0),
    .i_serial     (i_serial),
    .i_mode_select(i_mode_select),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 8N1 frame, LSB first; stop_bit lets a framing error be forced.
  task automatic send(input logic [7:0] d, input logic stop_bit);
    i_serial = 1'b0;
    repeat (C) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      i_serial = d[i];
      repeat (C) @(negedge sys_clk);
    end
    i_serial = stop_bit;
    repeat (C) @(negedge sys_clk);
    i_serial = 1'b1;
    $display("tx byte=%h stop=%0b mode=%0b", d, stop_bit, i_mode_select);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((byte_q.size() != 0 || word_q.size() != 0 || err_exp != 0) && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk($sformatf("%s_bytes_left", tag), 32'(byte_q.size()), 32'd0);
    chk($sformatf("%s_words_left", tag), 32'(word_q.size()), 32'd0);
    chk($sformatf("%s_errs_left", tag), 32'(err_exp), 32'd0);
    byte_q.delete();
    word_q.delete();
    err_exp = 0;
    repeat (4) @(negedge sys_clk);
    chk($sformatf("%s_busy_idle", tag), 32'(o_busy), 32'd0);
  endtask

  always @(negedge sys_clk) begin
    logic [7:0]  eb;
    logic [31:0] ew;
    if (o_byte_valid) begin
      chk("byte_expected", 32'(byte_q.size() > 0), 32'd1);
      if (byte_q.size() > 0) begin
        eb = byte_q.pop_front();
        chk("byte_value", 32'(o_byte), 32'(eb));
        $display("rx byte=%h expected=%h", o_byte, eb);
      end
    end
    if (o_word_valid) begin
      chk("word_expected", 32'(word_q.size() > 0), 32'd1);
      chk("word_with_byte", 32'(o_byte_valid), 32'd1);
      if (word_q.size() > 0) begin
        ew = word_q.pop_front();
        chk("word_value", o_word, ew);
        $display("rx word=%h expected=%h", o_word, ew);
      end
    end
    if (o_frame_err) begin
      chk("err_expected", 32'(err_exp > 0), 32'd1);
      chk("err_no_byte", 32'(o_byte_valid), 32'd0);
      if (err_exp > 0) err_exp--;
      $display("rx frame_err");
    end
    if (prev_bv) chk("byte_pulse_width", 32'(o_byte_valid), 32'd0);
    if (prev_wv) chk("word_pulse_width", 32'(o_word_valid), 32'd0);
    if (prev_fe) chk("err_pulse_width", 32'(o_frame_err), 32'd0);
    prev_bv = o_byte_valid;
    prev_wv = o_word_valid;
    prev_fe = o_frame_err;
  end

  initial begin
    logic [7:0] w2[4];
    logic [7:0] w4[4];
    logic [7:0] w6[4];
    w2 = '{8'h00, 8'hFF, 8'h12, 8'hCD};
    w4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    w6 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_byte", 32'(o_byte), 32'd0);
    chk("rst_word", o_word, 32'd0);
    chk("rst_byte_valid", 32'(o_byte_valid), 32'd0);
    chk("rst_word_valid", 32'(o_word_valid), 32'd0);
    chk("rst_frame_err", 32'(o_frame_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    sw_0 = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Byte mode single byte
    i_mode_select = 1'b0;
    byte_q.push_back(8'hAB);
    send(8'hAB, 1'b1);
    drain("t1");
    chk("t1_byte_hold", 32'(o_byte), 32'h0000_00AB);
    chk("t1_word_hold", o_word, 32'd0);

    // Word mode, back-to-back frames
    i_mode_select = 1'b1;
    for (int i = 0; i < 4; i++) byte_q.push_back(w2[i]);
    word_q.push_back(32'h00FF_12CD);
    for (int i = 0; i < 4; i++) send(w2[i], 1'b1);
    drain("t2");
    chk("t2_word_hold", o_word, 32'h00FF_12CD);

    // Short low glitch on the idle line
    i_serial = 1'b0;
    repeat (5) @(negedge sys_clk);
    i_serial = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("t3_busy_glitch", 32'(o_busy), 32'd0);
    repeat (2 * C) @(negedge sys_clk);
    chk("t3_byte_unchanged", 32'(o_byte), 32'h0000_00CD);
    i_mode_select = 1'b0;
    byte_q.push_back(8'h10);
    send(8'h10, 1'b1);
    drain("t3");
    chk("t3_byte_hold", 32'(o_byte), 32'h0000_0010);

    // Framing error discards the partial word
    i_mode_select = 1'b1;
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hBB);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    err_exp = 1;
    send(8'h33, 1'b0);
    repeat (3 * C) @(negedge sys_clk);
    drain("t4err");
    for (int i = 0; i < 4; i++) byte_q.push_back(w4[i]);
    word_q.push_back(32'h0102_0304);
    for (int i = 0; i < 4; i++) send(w4[i], 1'b1);
    drain("t4");
    chk("t4_word_hold", o_word, 32'h0102_0304);

    // Reset in the middle of the data bits
    i_mode_select = 1'b0;
    i_serial = 1'b0;
    repeat (C) @(negedge sys_clk);
    i_serial = 1'b1;
    repeat (C) @(negedge sys_clk);
    i_serial = 1'b0;
    repeat (C / 2) @(negedge sys_clk);
    chk("t5_busy_mid", 32'(o_busy), 32'd1);
    #2 sw_0 = 1'b0;
    #1;
    chk("t5_rst_byte", 32'(o_byte), 32'd0);
    chk("t5_rst_word", o_word, 32'd0);
    chk("t5_rst_busy", 32'(o_busy), 32'd0);
    chk("t5_rst_pulses", {29'd0, o_byte_valid, o_word_valid, o_frame_err}, 32'd0);
    @(negedge sys_clk);
    i_serial = 1'b1;
    sw_0 = 1'b1;
    repeat (2 * C) @(negedge sys_clk);
    byte_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    drain("t5");
    chk("t5_byte_hold", 32'(o_byte), 32'h0000_005A);

    // Mode switch mid-word clears the accumulator
    i_mode_select = 1'b1;
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    i_mode_select = 1'b0;
    byte_q.push_back(8'h77);
    send(8'h77, 1'b1);
    drain("t6a");
    chk("t6_word_unchanged", o_word, 32'd0);
    i_mode_select = 1'b1;
    for (int i = 0; i < 4; i++) byte_q.push_back(w6[i]);
    word_q.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) send(w6[i], 1'b1);
    drain("t6");
    chk("t6_word_hold", o_word, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
